mux_tree_pipe: RTL

//  Parametrised N-to-1, WIDTH-bit selector built as a binary tree of 2:1 muxes, one register rank per tree level.

---
 rtl/mux_pkg.sv | 28 ++
 rtl/mux2_w.sv | 21 ++
 rtl/mux_tree_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants and elaboration-time helpers for the pipelined mux tree.
//   MUX_MAX_N  : largest channel count the tree is built for
//   clog2_int  : ceil(log2(value)), used to derive the tree depth from N
//   is_pow2    : true when value is a positive power of two
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_MAX_N = 64;

    function automatic int clog2_int(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux2_w.sv
// ---------------------------------------------------------------------------
// mux2_w
// Combinational WIDTH-bit 2:1 multiplexer; one tree node of mux_tree_pipe.
// Ports:
//   in0  in   WIDTH  operand chosen when sel = 0 (lower channel index)
//   in1  in   WIDTH  operand chosen when sel = 1 (higher channel index)
//   sel  in   1      select
//   out  out  WIDTH  selected operand
// ---------------------------------------------------------------------------
module mux2_w #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe
// N-to-1, WIDTH-bit selector built as a binary tree of 2:1 muxes with one
// register rank per tree level, so the request takes exactly LEVELS enabled
// edges to reach the output. A valid bit travels alongside the data.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   en         in   1          1 = pipeline advances, 0 = every rank holds
//   flush      in   1          clears every rank's valid bit (wins over en=0)
//   in_valid   in   1          current in/sel pair is a real request
//   in         in   N*WIDTH    channel k at in[k*WIDTH +: WIDTH]
//   sel        in   LEVELS     channel index, unsigned
//   out        out  WIDTH      selected channel, LEVELS cycles after capture
//   out_valid  out  1          out carries a valid result
// ---------------------------------------------------------------------------
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 64,
    parameter  int N      = 8,
    localparam int LEVELS = clog2_int(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [N*WIDTH-1:0]   in,
    input  logic [LEVELS-1:0]    sel,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid
);

    if (!is_pow2(N) || (N < 2) || (N > MUX_MAX_N) || (WIDTH < 1)) begin : g_param_check
        $error("mux_tree_pipe: N must be a power of two in [2, MUX_MAX_N] and WIDTH >= 1");
    end

    genvar gi, gk;

    // Level gi reduces N>>gi operands to N>>(gi+1) results and registers them.
    for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
        localparam int NODES = N >> (gi + 1);

        logic [WIDTH-1:0] opnd_w [2*NODES];
        logic [WIDTH-1:0] data_d [NODES];
        logic [WIDTH-1:0] data_q [NODES];
        logic             sel_bit_w;
        logic             valid_in_w;
        logic             valid_d;
        logic             valid_q;

        // Operand source: the raw channels for the first level, the previous
        // rank for every later level. The select bit for level gi is sel[gi];
        // later levels find it at bit 0 of the previous rank's shifted copy.
        if (gi == 0) begin : g_src
            for (gk = 0; gk < 2*NODES; gk++) begin : g_op
                assign opnd_w[gk] = in[gk*WIDTH +: WIDTH];
            end
            assign sel_bit_w  = sel[0];
            assign valid_in_w = in_valid;
        end else begin : g_src
            for (gk = 0; gk < 2*NODES; gk++) begin : g_op
                assign opnd_w[gk] = g_lvl[gi-1].data_q[gk];
            end
            assign sel_bit_w  = g_lvl[gi-1].g_sel.sel_q[0];
            assign valid_in_w = g_lvl[gi-1].valid_q;
        end

        for (gk = 0; gk < NODES; gk++) begin : g_node
            mux2_w #(
                .WIDTH (WIDTH)
            ) u_mux (
                .in0 (opnd_w[2*gk]),
                .in1 (opnd_w[2*gk+1]),
                .sel (sel_bit_w),
                .out (data_d[gk])
            );
        end

        // Flush takes priority over both advance and hold.
        always_comb begin
            valid_d = valid_q;
            if (en) begin
                valid_d = valid_in_w;
            end
            if (flush) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= 1'b0;
                for (int k = 0; k < NODES; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                valid_q <= valid_d;
                if (en) begin
                    for (int k = 0; k < NODES; k++) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end
        end

        // Select bits still needed downstream, stored shifted so that bit 0
        // is always the select for the next level. The last rank needs none.
        if (gi < LEVELS - 1) begin : g_sel
            logic [LEVELS-2-gi:0] sel_d;
            logic [LEVELS-2-gi:0] sel_q;

            if (gi == 0) begin : g_sel_src
                assign sel_d = sel[LEVELS-1:1];
            end else begin : g_sel_src
                assign sel_d = g_lvl[gi-1].g_sel.sel_q[LEVELS-1-gi:1];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sel_q <= '0;
                end else if (en) begin
                    sel_q <= sel_d;
                end
            end
        end
    end

    // Outputs come straight from the last rank: no input-to-output comb path.
    assign out       = g_lvl[LEVELS-1].data_q[0];
    assign out_valid = g_lvl[LEVELS-1].valid_q;

endmodule
